// File: rtl/nout_serializer.sv
// nout_serializer: buffers 51-bit accumulator result words in a small FIFO
// and streams each one out as four 16-bit beats over a valid/ready interface.
// Beat 0 carries the low bits. Beat 3 carries the top 3 bits, zero-extended.
module nout_serializer #(
    parameter int DEPTH  = 2,
    parameter int BEAT_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [50:0]       nout,
    input  logic              cap,
    output logic [BEAT_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              full,
    output logic              ovf,
    input  logic              clr_ovf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    logic [50:0]       r_mem [DEPTH];
    logic [PW-1:0]     r_wrPtr;
    logic [PW-1:0]     r_rdPtr;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_beat;
    state_t            r_state;
    logic [BEAT_W-1:0] r_dout;
    logic              r_doutValid;
    logic              r_doutLast;
    logic              r_full;
    logic              r_ovf;

    logic              w_hs;
    logic              w_pop;
    logic              w_write;
    logic              w_drop;
    logic [PW-1:0]     w_wrPtrNext;
    logic [PW-1:0]     w_rdPtrNext;
    logic [CW-1:0]     w_countNext;
    logic [1:0]        w_beatNext;
    logic              w_sendNext;
    logic [50:0]       w_headNext;
    logic [BEAT_W-1:0] w_beatData;

    // A full buffer can still take a capture when the head word leaves in the same cycle.
    assign w_hs    = (r_state == S_SEND) && dout_ready;
    assign w_pop   = w_hs && (r_beat == 2'd3);
    assign w_write = cap && ((r_count != DEPTH_C) || w_pop);
    assign w_drop  = cap && !w_write;

    // Next-cycle pointers, occupancy, beat index and head word.
    // The registered outputs are loaded from these values, so a fresh word shows up one cycle after capture.
    always_comb begin
        w_wrPtrNext = r_wrPtr;
        w_rdPtrNext = r_rdPtr;
        w_countNext = r_count;
        w_beatNext  = r_beat;
        if (w_write) begin
            w_wrPtrNext = r_wrPtr + 1'b1;
        end
        if (w_pop) begin
            w_rdPtrNext = r_rdPtr + 1'b1;
        end
        case ({w_write, w_pop})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
        if (w_hs) begin
            w_beatNext = r_beat + 2'd1;
        end
        w_sendNext = (w_countNext != '0);
        // When the word being written is the only one left, the memory slot is not readable yet.
        if (w_write && (w_countNext == CW'(1))) begin
            w_headNext = nout;
        end else begin
            w_headNext = r_mem[w_rdPtrNext];
        end
    end

    // Select the 16-bit slice of the next head word for the next beat.
    always_comb begin
        w_beatData = '0;
        case (w_beatNext)
            2'd0:    w_beatData = w_headNext[15:0];
            2'd1:    w_beatData = w_headNext[31:16];
            2'd2:    w_beatData = w_headNext[47:32];
            default: w_beatData = {13'b0, w_headNext[50:48]};
        endcase
    end

    // FIFO storage needs no reset. Stale entries are never presented, because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wrPtr] <= nout;
        end
    end

    // Output FSM, FIFO bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_beat      <= 2'd0;
            r_dout      <= '0;
            r_doutValid <= 1'b0;
            r_doutLast  <= 1'b0;
            r_full      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_wrPtr <= w_wrPtrNext;
            r_rdPtr <= w_rdPtrNext;
            r_count <= w_countNext;
            r_beat  <= w_beatNext;
            case (r_state)
                S_IDLE: begin
                    if (w_sendNext) begin
                        r_state <= S_SEND;
                    end
                end
                default: begin
                    if (!w_sendNext) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
            r_doutValid <= w_sendNext;
            r_dout      <= w_sendNext ? w_beatData : '0;
            r_doutLast  <= w_sendNext && (w_beatNext == 2'd3);
            r_full      <= (w_countNext == DEPTH_C);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_doutValid;
    assign dout_last  = r_doutLast;
    assign full       = r_full;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_nout_serializer.sv
// tb_nout_serializer: fixed vectors, hand-written corner sequences, and random traffic
// checked against a queue-based model of the serializer.
module tb_nout_serializer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [50:0] nout = '0;
    logic        cap = 1'b0;
    logic        dout_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        full;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    nout_serializer #(.DEPTH(DEPTH), .BEAT_W(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .nout       (nout),
        .cap        (cap),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .full       (full),
        .ovf        (ovf),
        .clr_ovf    (clr_ovf)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        c;
        logic [50:0] n;
        logic        r;
        logic        cl;
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        f;
        logic        o;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the words held, in order, plus the beat index within the head word.
    logic [50:0] mQ[$];
    int          mBeat = 0;
    logic        mOvf = 1'b0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic v, input logic [15:0] d,
                            input logic l, input logic f, input logic o);
        checkOutput({tag, " valid"}, {15'b0, dout_valid}, {15'b0, v});
        checkOutput({tag, " dout"},  dout, d);
        checkOutput({tag, " last"},  {15'b0, dout_last}, {15'b0, l});
        checkOutput({tag, " full"},  {15'b0, full}, {15'b0, f});
        checkOutput({tag, " ovf"},   {15'b0, ovf}, {15'b0, o});
    endtask

    task automatic applyStimulus(input logic c, input logic [50:0] n, input logic r, input logic cl);
        @(negedge clk);
        cap        = c;
        nout       = n;
        dout_ready = r;
        clr_ovf    = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic c, input logic [50:0] n, input logic r, input logic cl,
                          input logic v, input logic [15:0] d, input logic l, input logic f, input logic o);
        vec_t e;
        e = '{c: c, n: n, r: r, cl: cl, v: v, d: d, l: l, f: f, o: o};
        vecs.push_back(e);
    endtask

    function automatic logic [15:0] modelDout();
        logic [50:0] w;
        if (mQ.size() == 0) return 16'h0000;
        w = mQ[0] >> (16 * mBeat);
        return w[15:0];
    endfunction

    task automatic modelReset();
        mQ.delete();
        mBeat = 0;
        mOvf  = 1'b0;
    endtask

    task automatic modelStep(input logic c, input logic [50:0] n, input logic r, input logic cl);
        bit valid, hs, pop, wr;
        valid = (mQ.size() > 0);
        hs    = valid && r;
        pop   = hs && (mBeat == 3);
        wr    = c && ((mQ.size() < DEPTH) || pop);
        if (hs) mBeat = (mBeat + 1) % 4;
        if (pop) mQ.delete(0);
        if (wr) mQ.push_back(n);
        if (c && !wr) mOvf = 1'b1;
        else if (cl) mOvf = 1'b0;
    endtask

    localparam logic [50:0] W  = 51'h7_1234_5678_9ABC;
    localparam logic [50:0] WA = 51'h1_AAAA_BBBB_CCCC;
    localparam logic [50:0] WB = 51'h2_1111_2222_3333;
    localparam logic [50:0] WC = 51'h3_4444_5555_6666;
    localparam logic [50:0] WX = 51'h5_0123_4567_89AB;
    localparam logic [50:0] WY = 51'h6_0F0F_F0F0_1357;
    localparam logic [50:0] WZ = 51'h4_DEAD_BEEF_CAFE;

    initial begin
        // Single word streamed straight through.
        addVec(1, W, 1, 0,  1, 16'h9ABC, 0, 0, 0);
        addVec(0, 0, 1, 0,  1, 16'h5678, 0, 0, 0);
        addVec(0, 0, 1, 0,  1, 16'h1234, 0, 0, 0);
        addVec(0, 0, 1, 0,  1, 16'h0007, 1, 0, 0);
        addVec(0, 0, 1, 0,  0, 16'h0000, 0, 0, 0);
        // Backpressure holding beat 1 for three cycles.
        addVec(1, W, 1, 0,  1, 16'h9ABC, 0, 0, 0);
        addVec(0, 0, 1, 0,  1, 16'h5678, 0, 0, 0);
        addVec(0, 0, 0, 0,  1, 16'h5678, 0, 0, 0);
        addVec(0, 0, 0, 0,  1, 16'h5678, 0, 0, 0);
        addVec(0, 0, 0, 0,  1, 16'h5678, 0, 0, 0);
        addVec(0, 0, 1, 0,  1, 16'h1234, 0, 0, 0);
        addVec(0, 0, 1, 0,  1, 16'h0007, 1, 0, 0);
        addVec(0, 0, 1, 0,  0, 16'h0000, 0, 0, 0);
        // Overflow: third capture dropped, only words 1 and 2 emitted.
        addVec(1, 51'd1, 0, 0,  1, 16'h0001, 0, 0, 0);
        addVec(1, 51'd2, 0, 0,  1, 16'h0001, 0, 1, 0);
        addVec(1, 51'd3, 0, 0,  1, 16'h0001, 0, 1, 1);
        addVec(0, 0, 1, 0,  1, 16'h0000, 0, 1, 1);
        addVec(0, 0, 1, 0,  1, 16'h0000, 0, 1, 1);
        addVec(0, 0, 1, 0,  1, 16'h0000, 1, 1, 1);
        addVec(0, 0, 1, 0,  1, 16'h0002, 0, 0, 1);
        addVec(0, 0, 1, 0,  1, 16'h0000, 0, 0, 1);
        addVec(0, 0, 1, 0,  1, 16'h0000, 0, 0, 1);
        addVec(0, 0, 1, 0,  1, 16'h0000, 1, 0, 1);
        addVec(0, 0, 1, 0,  0, 16'h0000, 0, 0, 1);
        addVec(0, 0, 1, 1,  0, 16'h0000, 0, 0, 0);
        // Full buffer, capture coincident with the beat-3 handshake.
        addVec(1, WA, 0, 0, 1, 16'hCCCC, 0, 0, 0);
        addVec(1, WB, 0, 0, 1, 16'hCCCC, 0, 1, 0);
        addVec(0, 0, 1, 0,  1, 16'hBBBB, 0, 1, 0);
        addVec(0, 0, 1, 0,  1, 16'hAAAA, 0, 1, 0);
        addVec(0, 0, 1, 0,  1, 16'h0001, 1, 1, 0);
        addVec(1, WC, 1, 0, 1, 16'h3333, 0, 1, 0);
        addVec(0, 0, 1, 0,  1, 16'h2222, 0, 1, 0);
        addVec(0, 0, 1, 0,  1, 16'h1111, 0, 1, 0);
        addVec(0, 0, 1, 0,  1, 16'h0002, 1, 1, 0);
        addVec(0, 0, 1, 0,  1, 16'h6666, 0, 0, 0);
        addVec(0, 0, 1, 0,  1, 16'h5555, 0, 0, 0);
        addVec(0, 0, 1, 0,  1, 16'h4444, 0, 0, 0);
        addVec(0, 0, 1, 0,  1, 16'h0003, 1, 0, 0);
        addVec(0, 0, 1, 0,  0, 16'h0000, 0, 0, 0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkAll("reset", 0, 16'h0000, 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].c, vecs[i].n, vecs[i].r, vecs[i].cl);
            checkAll($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].f, vecs[i].o);
        end

        // Drop coincident with clr_ovf: set wins. Then a plain clear.
        applyStimulus(1, WX, 0, 0);
        applyStimulus(1, WY, 0, 0);
        checkOutput("fill full", {15'b0, full}, 16'h0001);
        applyStimulus(1, WZ, 0, 1);
        checkOutput("drop+clr ovf", {15'b0, ovf}, 16'h0001);
        applyStimulus(0, 0, 0, 1);
        checkOutput("clr ovf", {15'b0, ovf}, 16'h0000);

        // Advance to beat 2 of the first word, then reset asynchronously.
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("pre-reset beat2", dout, 16'h0123);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkAll("async reset", 0, 16'h0000, 0, 0, 0);
        @(negedge clk);
        dout_ready = 1'b1;
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 1, 0);
            checkAll($sformatf("post-reset%0d", i), 0, 16'h0000, 0, 0, 0);
        end
        applyStimulus(1, W, 1, 0);
        checkAll("new cap after reset", 1, 16'h9ABC, 0, 0, 0);

        // Random traffic against the model, from a clean reset.
        @(negedge clk);
        rstn = 1'b0;
        cap = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        modelReset();
        for (int i = 0; i < 3000; i++) begin
            logic        c, r, cl;
            logic [50:0] n;
            c  = ($urandom_range(0, 99) < 40);
            r  = ($urandom_range(0, 99) < 60);
            cl = ($urandom_range(0, 99) < 5);
            n  = {$urandom, $urandom};
            applyStimulus(c, n, r, cl);
            modelStep(c, n, r, cl);
            checkAll($sformatf("rand%0d", i), (mQ.size() > 0), modelDout(),
                     (mQ.size() > 0) && (mBeat == 3), (mQ.size() == DEPTH), mOvf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
